// File: rtl/calc_display_rx_pkg.sv
// Shared types and constants for the calculator display receiver:
// FSM states, sender status codes and active-low 7-segment patterns.
package calc_display_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COMMIT,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    SEL_DIGIT,
    SEL_BLANK,
    SEL_E,
    SEL_R
  } segsel_e;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  function automatic logic [6:0] bcdToSeg(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/calc_display_rx_seg7_enc.sv
// Combinational 7-segment encoder: BCD digit, blank, or the letters E / r.
module seg7_enc
  import calc_display_rx_pkg::*;
(
  input  logic [3:0] code_i,
  input  segsel_e    sel_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (sel_i)
      SEL_DIGIT: seg_o = bcdToSeg(code_i);
      SEL_E:     seg_o = SEG_E;
      SEL_R:     seg_o = SEG_R;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display_rx.sv
// Receives BCD digits from a sender into a shadow frame, commits whole frames
// to the display buffer and scans them onto a multiplexed 8-digit display.
module calc_display_rx
  import calc_display_rx_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done,
  output logic       err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e           state_q, state_d;
  logic [7:0][3:0]  shadow_q, shadow_d;
  logic [7:0][3:0]  dispBuf_q, dispBuf_d;
  logic [7:0]       mask_q, mask_d;
  logic             frameDone_q, frameDone_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             captureEn;
  logic [7:0]       zeroFrom;
  logic [3:0]       encCode;
  segsel_e          encSel;

  assign captureEn = (status == ST_BUSY) && !pos[3];

  // Error status outranks everything, so it is tested first in every state.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    mask_d      = mask_q;
    dispBuf_d   = dispBuf_q;
    frameDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (status == ST_ERR) begin
          state_d = ERROR;
        end else if (captureEn) begin
          shadow_d[pos[2:0]] = data;
          mask_d[pos[2:0]]   = 1'b1;
          state_d            = CAPTURE;
        end
      end
      CAPTURE: begin
        if (status == ST_ERR) begin
          state_d = ERROR;
        end else if (captureEn) begin
          shadow_d[pos[2:0]] = data;
          mask_d[pos[2:0]]   = 1'b1;
        end else if (status == ST_READY && mask_q != 8'd0) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (status == ST_ERR) begin
          state_d = ERROR;
        end else begin
          dispBuf_d   = shadow_q;
          mask_d      = 8'd0;
          frameDone_d = 1'b1;
          state_d     = IDLE;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // an and seg are derived from next-state values so both register on the same edge.
  always_comb begin
    zeroFrom    = 8'd0;
    zeroFrom[7] = (dispBuf_d[7] == 4'd0);
    for (int i = 6; i >= 0; i--) begin
      zeroFrom[i] = (dispBuf_d[i] == 4'd0) && zeroFrom[i+1];
    end
    encCode = dispBuf_d[idx_d];
    encSel  = SEL_DIGIT;
    if (state_d == ERROR) begin
      case (idx_d)
        3'd0, 3'd1: encSel = SEL_R;
        3'd2:       encSel = SEL_E;
        default:    encSel = SEL_BLANK;
      endcase
    end else if (BLANK_LZ && idx_d != 3'd0 && zeroFrom[idx_d]) begin
      encSel = SEL_BLANK;
    end
    an_d = ~(8'h01 << idx_d);
  end

  seg7_enc u_seg7_enc (
    .code_i(encCode),
    .sel_i (encSel),
    .seg_o (seg_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      dispBuf_q   <= '0;
      mask_q      <= 8'd0;
      frameDone_q <= 1'b0;
      div_q       <= '0;
      idx_q       <= 3'd0;
      an_q        <= 8'hFE;
      seg_q       <= SEG_0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      dispBuf_q   <= dispBuf_d;
      mask_q      <= mask_d;
      frameDone_q <= frameDone_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frameDone_q;
  assign err        = (state_q == ERROR);

endmodule
